// File: rtl/conv_result_trimmer.sv
// Trims group-delay head/tail results from the 11-tap convolution stream and
// emits KEEP rounded, narrowed samples per frame. `CONV_TRIM_SAT_EN selects clamping.
module conv_result_trimmer #(
   parameter int IN_W     = 32,
   parameter int OUT_W    = 16,
   parameter int FRAME_IN = 110,
   parameter int SKIP     = 5,
   parameter int KEEP     = 100,
   parameter int SHIFT    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_r,
   input  logic [IN_W-1:0]  in_i,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_r,
   output logic [OUT_W-1:0] out_i,
   output logic             out_first,
   output logic             out_last,
   output logic             frame_err,
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and payload holds while valid && !ready.

   localparam int IDX_W = (FRAME_IN > 1) ? $clog2(FRAME_IN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_IN - 1);
   localparam logic [IDX_W-1:0] PASS_LO  = IDX_W'(SKIP);
   localparam logic [IDX_W-1:0] PASS_HI  = IDX_W'(SKIP + KEEP - 1);
   localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) <<< (SHIFT - 1);
`ifdef CONV_TRIM_SAT_EN
   localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [IN_W:0] SAT_MIN = -((IN_W+1)'(2 ** (OUT_W - 1)));
`endif

   typedef enum logic [1:0] {
      ST_HEAD = 2'd0,
      ST_PASS = 2'd1,
      ST_TAIL = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] idx, idx_next;
   logic             fire;
   logic             is_end;
   logic             early_end;
   logic             late_end;
   logic             load;

   // Round half toward +inf, then narrow (clamp or wrap depending on build).
   function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0] x);
      logic signed [IN_W:0] ext;
      logic signed [IN_W:0] sh;
      ext = signed'({x[IN_W-1], x}) + RND;
      sh  = ext >>> SHIFT;
`ifdef CONV_TRIM_SAT_EN
      if (sh > SAT_MAX)
         scale = SAT_MAX[OUT_W-1:0];
      else if (sh < SAT_MIN)
         scale = SAT_MIN[OUT_W-1:0];
      else
         scale = sh[OUT_W-1:0];
`else
      scale = sh[OUT_W-1:0];
`endif
   endfunction

   function automatic state_t region(input logic [IDX_W-1:0] i);
      if (i < PASS_LO)
         region = ST_HEAD;
      else if (i <= PASS_HI)
         region = ST_PASS;
      else
         region = ST_TAIL;
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_HEAD;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // Next-state logic: position advances only on an accepted result
   always_comb begin
      is_end     = (idx == LAST_IDX);
      early_end  = fire && in_last && !is_end;
      late_end   = fire && is_end && !in_last;
      idx_next   = idx;
      state_next = state;
      if (fire) begin
         if (is_end || early_end)
            idx_next = '0;
         else
            idx_next = idx + 1'b1;
         state_next = region(idx_next);
      end
   end

   // Output logic; in_ready in PASS is combinational from out_ready
   always_comb begin
      in_ready  = 1'b1;
      if (state == ST_PASS)
         in_ready = !out_valid || out_ready;
      fire      = in_valid && in_ready;
      load      = fire && (state == ST_PASS) && !in_last;
      dbg_state = state;
   end

   // Output register: load wins over consume so back-to-back keeps valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_r     <= scale(in_r);
         out_i     <= scale(in_i);
         out_first <= (idx == PASS_LO);
         out_last  <= (idx == PASS_HI);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_err <= 1'b0;
      else
         frame_err <= early_end || late_end;
   end

endmodule

// File: tb/tb_conv_result_trimmer.sv
// Directed bench for conv_result_trimmer: framing, rounding, narrowing,
// backpressure, early end and mid-frame reset.
module tb_conv_result_trimmer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_r;
   logic [31:0] in_i;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_r;
   logic [15:0] out_i;
   logic        out_first;
   logic        out_last;
   logic        frame_err;
   logic [1:0]  dbg_state;

   conv_result_trimmer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_i(in_i), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_i(out_i),
      .out_first(out_first), .out_last(out_last),
      .frame_err(frame_err), .dbg_state(dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int fails = 0;

   logic [15:0] rx_r[$];
   logic [15:0] rx_i[$];
   logic        rx_first[$];
   logic        rx_last[$];
   logic [15:0] exp_q[$];
   int err_cnt, fire_total, fire6_cycle, first_valid_cycle, cycle;
   int stall_bad, timeouts;
   logic stall_pend;
   logic [17:0] hold_val;
   logic bp_mode;

   task automatic clear_obs();
      rx_r.delete(); rx_i.delete(); rx_first.delete(); rx_last.delete();
      err_cnt = 0; fire_total = 0; fire6_cycle = -1; first_valid_cycle = -1;
      cycle = 0; stall_bad = 0; timeouts = 0; stall_pend = 1'b0;
   endtask

   // driver: one clock of stimulus, sampled 1 ns after the falling edge
   task automatic drive_cycle(input logic v, input logic [31:0] r, input logic [31:0] i,
                              input logic last, input logic ordy, output logic fired);
      @(negedge clk);
      in_valid = v; in_r = r; in_i = i; in_last = last; out_ready = ordy;
      #1;
      fired = v && in_ready;
      if (fired) begin
         fire_total++;
         if (fire_total == 6) fire6_cycle = cycle;
      end
      if (out_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
      if (stall_pend && (!out_valid || {out_r[15:0], out_first, out_last} != hold_val))
         stall_bad++;
      stall_pend = out_valid && !out_ready;
      hold_val = {out_r, out_first, out_last};
      if (out_valid && out_ready) begin
         rx_r.push_back(out_r); rx_i.push_back(out_i);
         rx_first.push_back(out_first); rx_last.push_back(out_last);
      end
      if (frame_err) err_cnt++;
      cycle++;
   endtask

   task automatic send(input logic [31:0] r, input logic [31:0] i, input logic last);
      logic fired;
      int tries;
      fired = 1'b0;
      tries = 0;
      while (!fired && tries < 64) begin
         drive_cycle(1'b1, r, i, last, bp_mode ? 1'($urandom_range(0, 1)) : 1'b1, fired);
         tries++;
      end
      if (!fired) timeouts++;
   endtask

   task automatic idle(input int n);
      logic fired;
      for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, fired);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 0; in_r = 0; in_i = 0; in_last = 0; out_ready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({out_valid, out_r, out_i, out_first, out_last, frame_err} !== 35'd0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b r=%h i=%h f=%b l=%b e=%b, want all 0",
                  out_valid, out_r, out_i, out_first, out_last, frame_err);
      end
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (dbg_state !== 2'd0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: got state=%0d in_ready=%b, want 0/1", dbg_state, in_ready);
      end
   endtask

   task automatic test_constant();
      int bad, nfirst, nlast;
      clear_obs(); bp_mode = 1'b0;
      for (int k = 0; k < 110; k++) send(32'd1600, -32'sd1600, k == 109);
      tests_run++;
      if (cycle != 110) begin
         fails++; $display("FAIL const_throughput: got %0d cycles, want 110", cycle);
      end
      idle(4);
      tests_run++;
      if (rx_r.size() != 100) begin
         fails++; $display("FAIL const_count: got %0d, want 100", rx_r.size());
      end
      bad = 0; nfirst = 0; nlast = 0;
      foreach (rx_r[k]) begin
         if (rx_r[k] !== 16'd100 || rx_i[k] !== 16'hFF9C) bad++;
         if (rx_first[k]) nfirst++;
         if (rx_last[k]) nlast++;
      end
      tests_run++;
      if (bad != 0) begin
         fails++; $display("FAIL const_values: got %0d wrong samples, want 0", bad);
      end
      tests_run++;
      if (rx_r.size() != 100 || !rx_first[0] || !rx_last[99] || nfirst != 1 || nlast != 1) begin
         fails++; $display("FAIL const_flags: got first=%0d last=%0d, want 1/1 at 1/100", nfirst, nlast);
      end
      tests_run++;
      if (err_cnt != 0) begin
         fails++; $display("FAIL const_frame_err: got %0d pulses, want 0", err_cnt);
      end
      tests_run++;
      if (first_valid_cycle != fire6_cycle + 1) begin
         fails++; $display("FAIL const_latency: got valid at %0d, want %0d", first_valid_cycle, fire6_cycle + 1);
      end
   endtask

   task automatic test_rounding();
      int vals[5] = '{8, 7, -8, -9, 24};
      logic [15:0] want[5] = '{16'd1, 16'd0, 16'd0, 16'hFFFF, 16'd2};
      clear_obs(); bp_mode = 1'b0;
      for (int k = 0; k < 110; k++)
         send((k >= 5 && k < 10) ? 32'(vals[k-5]) : 32'd0, '0, k == 109);
      idle(4);
      for (int k = 0; k < 5; k++) begin
         tests_run++;
         if (rx_r.size() != 100 || rx_r[k] !== want[k]) begin
            fails++; $display("FAIL round_%0d: got %h, want %h", vals[k], rx_r.size() > k ? rx_r[k] : 16'hxxxx, want[k]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] wr, wi;
`ifdef CONV_TRIM_SAT_EN
      wr = 16'h7FFF; wi = 16'h8000;
`else
      wr = 16'hFFFF; wi = 16'h0000;
`endif
      clear_obs(); bp_mode = 1'b0;
      for (int k = 0; k < 110; k++)
         send(k == 5 ? 32'h7FFF_FFF0 : 32'd0, k == 5 ? 32'h8000_0000 : 32'd0, k == 109);
      idle(4);
      tests_run++;
      if (rx_r.size() == 0 || rx_r[0] !== wr || rx_i[0] !== wi) begin
         fails++; $display("FAIL saturation: got %h/%h, want %h/%h",
                           rx_r.size() > 0 ? rx_r[0] : 16'hxxxx, rx_i.size() > 0 ? rx_i[0] : 16'hxxxx, wr, wi);
      end
   endtask

   task automatic test_backpressure();
      int bad, nfirst, nlast;
      logic [15:0] e;
      clear_obs(); bp_mode = 1'b1; exp_q.delete();
      for (int f = 0; f < 2; f++)
         for (int k = 5; k < 105; k++) exp_q.push_back(16'((k + 8) >> 4));
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < 110; k++) send(32'(k), '0, k == 109);
      bp_mode = 1'b0;
      idle(4);
      tests_run++;
      if (rx_r.size() != 200) begin
         fails++; $display("FAIL bp_count: got %0d, want 200", rx_r.size());
      end
      bad = 0; nfirst = 0; nlast = 0;
      foreach (rx_r[k]) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
         if (rx_r[k] !== e) bad++;
         if (rx_first[k]) nfirst++;
         if (rx_last[k]) nlast++;
      end
      tests_run++;
      if (bad != 0 || exp_q.size() != 0) begin
         fails++; $display("FAIL bp_values: got %0d wrong, %0d missing, want 0/0", bad, exp_q.size());
      end
      tests_run++;
      if (nfirst != 2 || nlast != 2) begin
         fails++; $display("FAIL bp_flags: got first=%0d last=%0d, want 2/2", nfirst, nlast);
      end
      tests_run++;
      if (stall_bad != 0 || timeouts != 0 || err_cnt != 0) begin
         fails++; $display("FAIL bp_stall: got unstable=%0d timeouts=%0d err=%0d, want 0", stall_bad, timeouts, err_cnt);
      end
   endtask

   task automatic test_early_last();
      int nlast;
      clear_obs(); bp_mode = 1'b0;
      for (int k = 0; k < 50; k++) send(32'd160, '0, k == 49);
      idle(4);
      nlast = 0;
      foreach (rx_last[k]) if (rx_last[k]) nlast++;
      tests_run++;
      if (rx_r.size() != 44 || nlast != 0 || err_cnt != 1) begin
         fails++; $display("FAIL early_end: got %0d outputs last=%0d err=%0d, want 44/0/1", rx_r.size(), nlast, err_cnt);
      end
      tests_run++;
      if (dbg_state !== 2'd0) begin
         fails++; $display("FAIL early_resync: got state %0d, want 0", dbg_state);
      end
      clear_obs();
      for (int k = 0; k < 110; k++) send(32'd160, '0, k == 109);
      idle(4);
      tests_run++;
      if (rx_r.size() != 100 || !rx_first[0] || !rx_last[99] || err_cnt != 0 || rx_r[0] !== 16'd10) begin
         fails++; $display("FAIL early_next_frame: got %0d outputs err=%0d, want 100/0", rx_r.size(), err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int nfirst, nlast;
      clear_obs(); bp_mode = 1'b0;
      for (int k = 0; k < 60; k++) send(32'd32, '0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
         fails++; $display("FAIL mid_reset: got valid=%b state=%0d, want 0/0", out_valid, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
      for (int k = 0; k < 110; k++) send(32'd32, '0, k == 109);
      idle(4);
      nfirst = 0; nlast = 0;
      foreach (rx_r[k]) begin
         if (rx_first[k]) nfirst++;
         if (rx_last[k]) nlast++;
      end
      tests_run++;
      if (rx_r.size() != 100 || nfirst != 1 || nlast != 1 || !rx_first[0] || !rx_last[99]) begin
         fails++; $display("FAIL mid_reset_frame: got %0d outputs first=%0d last=%0d, want 100/1/1",
                           rx_r.size(), nfirst, nlast);
      end
   endtask

   initial begin
      bp_mode = 1'b0;
      clear_obs();
      test_reset();
      test_constant();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_early_last();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
